// File: rtl/vdp_sprite_pkg.sv
// Shared constants and types for the sprite-mode-2 per-line attribute scanner.
// Holds the SAT terminator value, scan limits and the scanner state encoding.
package vdp_sprite_pkg;

  localparam int MAX_SPRITES = 8;
  localparam int PLANES      = 32;
  localparam logic [7:0] SAT_TERMINATOR_Y = 8'd216;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_EVAL,
    ST_DONE
  } state_t;

  // Y byte of a plane lives at the first byte of its 4-byte SAT entry.
  function automatic logic [16:0] sat_y_addr(input logic [9:0] base, input logic [4:0] plane);
    return {base, plane, 2'b00};
  endfunction

endpackage

// File: rtl/vdp_sprite_ycompare.sv
// Vertical hit test for one sprite plane: decides whether the display line
// crosses the sprite and which pattern row (after magnify) it lands on.
module vdp_sprite_ycompare (
  input  logic [7:0] y,
  input  logic [7:0] line_y,
  input  logic       sp_16x16,
  input  logic       sp_magnify,
  output logic       hit,
  output logic [3:0] row
);

  logic [7:0] off;
  logic [5:0] size;

  // Sprites start one line below their Y; 8-bit wrap makes Y=255 cover line 0.
  always_comb begin
    off  = line_y - y - 8'd1;
    size = sp_16x16 ? 6'd16 : 6'd8;
    if (sp_magnify) size = {size[4:0], 1'b0};
    hit  = (off < {2'b00, size});
    row  = sp_magnify ? off[4:1] : off[3:0];
  end

endmodule

// File: rtl/vdp_sprite_select.sv
// Per-line SAT Y scanner: reads plane Y bytes from VRAM, emits up to MAX_SPRITES
// visible planes to pattern fetch, and maintains the S#0 5S flag and plane number.
module vdp_sprite_select
  import vdp_sprite_pkg::*;
#(
  parameter int MAX_SPRITES = vdp_sprite_pkg::MAX_SPRITES,
  parameter int PLANES      = vdp_sprite_pkg::PLANES
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        line_start,
  input  logic [7:0]  line_y,
  input  logic        reg_sp_disable,
  input  logic        reg_sp_16x16,
  input  logic        reg_sp_magnify,
  input  logic [9:0]  reg_sat_base,
  output logic        vram_req,
  output logic [16:0] vram_address,
  input  logic        vram_ack,
  input  logic        vram_rdata_en,
  input  logic [7:0]  vram_rdata,
  output logic        sel_we,
  output logic [2:0]  sel_index,
  output logic [4:0]  sel_plane,
  output logic [3:0]  sel_row,
  output logic        scan_done,
  output logic [3:0]  sel_count,
  input  logic        status_clear,
  output logic        status_5s,
  output logic [4:0]  status_plane,
  output state_t      dbg_state
);

  // VRAM handshake: vram_req stays high with a stable address until the cycle
  // vram_ack is seen; exactly one vram_rdata_en pulse follows, at least one
  // cycle later. Only one read is ever outstanding.

  state_t     state, state_nxt;
  logic [4:0] plane, plane_nxt;
  logic [3:0] count, count_nxt;
  logic [7:0] y_q;
  logic [7:0] line_y_q;
  logic       sp_16x16_q, sp_magnify_q;
  logic [9:0] sat_base_q;
  logic       cur_tag, rd_tag, rd_pending;
  logic       data_take;
  logic       hit;
  logic [3:0] row;
  logic       stop, set_5s, eval_upd;

  vdp_sprite_ycompare u_ycompare (
    .y          (y_q),
    .line_y     (line_y_q),
    .sp_16x16   (sp_16x16_q),
    .sp_magnify (sp_magnify_q),
    .hit        (hit),
    .row        (row)
  );

  // A read acked under an older line tag is drained but never evaluated.
  assign data_take = (state == ST_WAIT) && vram_rdata_en && rd_pending && (rd_tag == cur_tag);

  always_comb begin
    state_nxt = state;
    plane_nxt = plane;
    count_nxt = count;
    sel_we    = 1'b0;
    set_5s    = 1'b0;
    eval_upd  = 1'b0;
    stop      = 1'b0;
    case (state)
      ST_IDLE: ;
      ST_REQ:  if (vram_req && vram_ack) state_nxt = ST_WAIT;
      ST_WAIT: if (data_take) state_nxt = ST_EVAL;
      ST_EVAL: begin
        eval_upd = 1'b1;
        if (y_q == SAT_TERMINATOR_Y) begin
          stop = 1'b1;
        end else if (hit) begin
          if (count < 4'(MAX_SPRITES)) begin
            sel_we    = 1'b1;
            count_nxt = count + 4'd1;
          end else begin
            set_5s = !status_5s;
            stop   = 1'b1;
          end
        end
        if (plane == 5'(PLANES - 1)) stop = 1'b1;
        if (stop) begin
          state_nxt = ST_DONE;
        end else begin
          plane_nxt = plane + 5'd1;
          state_nxt = ST_REQ;
        end
      end
      ST_DONE: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
    if (line_start) begin
      sel_we    = 1'b0;
      set_5s    = 1'b0;
      eval_upd  = 1'b0;
      plane_nxt = 5'd0;
      count_nxt = 4'd0;
      state_nxt = reg_sp_disable ? ST_DONE : ST_REQ;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      plane        <= 5'd0;
      count        <= 4'd0;
      y_q          <= 8'd0;
      line_y_q     <= 8'd0;
      sp_16x16_q   <= 1'b0;
      sp_magnify_q <= 1'b0;
      sat_base_q   <= 10'd0;
      cur_tag      <= 1'b0;
      rd_tag       <= 1'b0;
      rd_pending   <= 1'b0;
      sel_count    <= 4'd0;
      status_5s    <= 1'b0;
      status_plane <= 5'd0;
    end else begin
      state <= state_nxt;
      plane <= plane_nxt;
      count <= count_nxt;
      if (line_start) begin
        line_y_q     <= line_y;
        sp_16x16_q   <= reg_sp_16x16;
        sp_magnify_q <= reg_sp_magnify;
        sat_base_q   <= reg_sat_base;
        cur_tag      <= ~cur_tag;
      end
      if (vram_req && vram_ack) begin
        rd_pending <= 1'b1;
        rd_tag     <= cur_tag;
      end else if (vram_rdata_en && rd_pending) begin
        rd_pending <= 1'b0;
      end
      if (data_take) y_q <= vram_rdata;
      if (state_nxt == ST_DONE) sel_count <= count_nxt;
      if (set_5s) begin
        status_5s    <= 1'b1;
        status_plane <= plane;
      end else begin
        if (status_clear) status_5s <= 1'b0;
        if (eval_upd && !status_5s) status_plane <= plane;
      end
    end
  end

  // Request is withheld while a stale read from an aborted scan is draining.
  assign vram_req     = (state == ST_REQ) && !rd_pending;
  assign vram_address = sat_y_addr(sat_base_q, plane);
  assign sel_index    = sel_we ? count[2:0] : 3'd0;
  assign sel_plane    = sel_we ? plane : 5'd0;
  assign sel_row      = sel_we ? row : 4'd0;
  assign scan_done    = (state == ST_DONE);
  assign dbg_state    = state;

endmodule
